// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the multi-channel LED controller: mode codes,
// per-channel FSM state encoding and the PWM counter width.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ON  = 2'd1,
    S_HI  = 2'd2,
    S_LO  = 2'd3
  } state_e;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] DUTY_RST = 8'hFF;

endpackage

// File: rtl/led_ch_fsm.sv
// One LED channel: mode FSM, phase counter and remaining-pulse counter.
// With LED_PWM_EN defined, it also holds a per-channel duty register and
// gates the lit state against the shared PWM counter.
//
// state | meaning
// S_OFF | dark, idle
// S_ON  | steadily lit, idle
// S_HI  | blink/pulse lit phase
// S_LO  | blink/pulse dark phase
module led_ch_fsm
  import led_ctrl_pkg::*;
#(
  parameter int PER_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [PER_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_cnt,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] cfg_duty,
  input  logic [PWM_W-1:0] pwm_cnt,
`endif
  output logic             led_on,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [PER_W-1:0] ctr_q, ctr_d;
  logic [PER_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             phase_end;
  logic             logical_on;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] duty_q, duty_d;
`endif

  // State register: synchronous reset clears everything, no done on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OFF;
      ctr_q   <= '0;
      half_q  <= PER_W'(1);
      rem_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef LED_PWM_EN
      duty_q  <= DUTY_RST;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      half_q  <= half_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
`ifdef LED_PWM_EN
      duty_q  <= duty_d;
`endif
    end
  end

  assign phase_end = tick && (ctr_q == (half_q - PER_W'(1)));

  // Next state: a config write always wins over the running sequence
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    half_d  = half_q;
    rem_d   = rem_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
`ifdef LED_PWM_EN
    duty_d  = duty_q;
`endif
    if (cfg_we) begin
      ctr_d   = '0;
      rem_d   = cfg_cnt;
      half_d  = (cfg_half == '0) ? PER_W'(1) : cfg_half;
      pulse_d = (mode_e'(cfg_mode) == MODE_PULSE);
`ifdef LED_PWM_EN
      duty_d  = cfg_duty;
`endif
      case (mode_e'(cfg_mode))
        MODE_OFF:   state_d = S_OFF;
        MODE_ON:    state_d = S_ON;
        MODE_BLINK: state_d = S_HI;
        MODE_PULSE: begin
          if (cfg_cnt == '0) begin
            state_d = S_OFF;
            done_d  = 1'b1;
          end else begin
            state_d = S_HI;
          end
        end
        default:    state_d = S_OFF;
      endcase
    end else if (tick && ((state_q == S_HI) || (state_q == S_LO))) begin
      if (phase_end) begin
        ctr_d = '0;
        if (state_q == S_HI) begin
          state_d = S_LO;
          if (pulse_q) rem_d = rem_q - CNT_W'(1);
        end else if (pulse_q && (rem_q == '0)) begin
          state_d = S_OFF;
          done_d  = 1'b1;
        end else begin
          state_d = S_HI;
        end
      end else begin
        ctr_d = ctr_q + PER_W'(1);
      end
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    logical_on = (state_q == S_ON) || (state_q == S_HI);
    busy       = (state_q == S_HI) || (state_q == S_LO);
    done       = done_q;
`ifdef LED_PWM_EN
    led_on     = logical_on && (pwm_cnt < duty_q);
`else
    led_on     = logical_on;
`endif
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller top: shared free-running prescaler, one-beat
// valid/ready config port, channel decode and N_CH channel FSM instances.
// Optional feature macro LED_PWM_EN adds the cfg_duty port and a shared
// 8-bit PWM counter for per-channel brightness.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter  int N_CH  = 3,
  parameter  int PRESC = 12000000,
  parameter  int PER_W = 8,
  parameter  int CNT_W = 8,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PER_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_cnt,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] cfg_duty,
`endif
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  done
);

  localparam int PRESC_W = $clog2(PRESC);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               ready_q, ready_d;
  logic               tick;
  logic               accept;
  logic [N_CH-1:0]    ch_we;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
`endif

  // Prescaler, handshake and PWM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      ready_q   <= 1'b0;
`ifdef LED_PWM_EN
      pwm_cnt_q <= '0;
`endif
    end else begin
      presc_q   <= presc_d;
      ready_q   <= ready_d;
`ifdef LED_PWM_EN
      pwm_cnt_q <= pwm_cnt_d;
`endif
    end
  end

  // Free-running timebase; ready drops for one cycle after each accept
  always_comb begin
    tick      = (presc_q == PRESC_W'(PRESC - 1));
    presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
    accept    = cfg_valid && ready_q;
    ready_d   = !accept;
    cfg_ready = ready_q;
`ifdef LED_PWM_EN
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
`endif
  end

  // Channel decode; out-of-range channels are accepted and dropped here
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_we[i] = accept && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_ch_fsm #(
      .PER_W (PER_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .cfg_we   (ch_we[g]),
      .cfg_mode (cfg_mode),
      .cfg_half (cfg_half),
      .cfg_cnt  (cfg_cnt),
`ifdef LED_PWM_EN
      .cfg_duty (cfg_duty),
      .pwm_cnt  (pwm_cnt_q),
`endif
      .led_on   (led[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
module tb_led_blink_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_half;
  logic [7:0] cfg_cnt;
`ifdef LED_PWM_EN
  logic [7:0] cfg_duty;
`endif
  logic [2:0] led;
  logic [2:0] busy;
  logic [2:0] done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_blink_ctrl #(
    .N_CH  (3),
    .PRESC (4),
    .PER_W (8),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_cnt   (cfg_cnt),
`ifdef LED_PWM_EN
    .cfg_duty  (cfg_duty),
`endif
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic       valid;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [7:0] cnt;
    logic [2:0] e_led;
    logic [2:0] e_busy;
    logic [2:0] e_done;
    logic       e_ready;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // With PWM the lit state may be gated dark, so only "never lit when off" is exact
  task automatic check_led(input string name, input logic [2:0] act, input logic [2:0] exp);
`ifdef LED_PWM_EN
    check(name, {29'd0, act & ~exp}, 32'd0);
`else
    check(name, {29'd0, act}, {29'd0, exp});
`endif
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [1:0] mode,
                        input logic [7:0] half, input logic [7:0] cnt);
    int guard;
    guard = 0;
    while (!cfg_ready && guard < 10) begin
      step();
      guard++;
    end
    if (!cfg_ready) check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_half  = half;
    cfg_cnt   = cnt;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic run_len(input int bitn, input logic lvl, output int len);
    len = 0;
    while (led[bitn] == lvl && len < 40) begin
      len++;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, l2, l3, n_done, n_dark;
    logic tl[64], tb[64], td[64];
    int rises, done_n, done_idx, last_hi;
    int hl[3];

    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_mode  = 2'd0;
    cfg_half  = 8'd1;
    cfg_cnt   = 8'd0;
`ifdef LED_PWM_EN
    cfg_duty  = 8'hFF;
`endif

    // valid, ch, mode, cnt, led, busy, done, ready (outputs after the edge)
    vecs[0]  = '{1'b1, 2'd1, 2'd1, 8'd0, 3'b010, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 2'd1, 8'd0, 3'b010, 3'b000, 3'b000, 1'b1};
    vecs[2]  = '{1'b1, 2'd1, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b1};
    vecs[4]  = '{1'b1, 2'd0, 2'd1, 8'd0, 3'b001, 3'b000, 3'b000, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 2'd1, 8'd0, 3'b001, 3'b000, 3'b000, 1'b1};
    vecs[6]  = '{1'b1, 2'd2, 2'd1, 8'd0, 3'b101, 3'b000, 3'b000, 1'b0};
    vecs[7]  = '{1'b0, 2'd2, 2'd1, 8'd0, 3'b101, 3'b000, 3'b000, 1'b1};
    vecs[8]  = '{1'b1, 2'd3, 2'd1, 8'd0, 3'b101, 3'b000, 3'b000, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 2'd1, 8'd0, 3'b101, 3'b000, 3'b000, 1'b1};
    vecs[10] = '{1'b1, 2'd0, 2'd0, 8'd0, 3'b100, 3'b000, 3'b000, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 2'd0, 8'd0, 3'b100, 3'b000, 3'b000, 1'b1};
    vecs[12] = '{1'b1, 2'd2, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[13] = '{1'b0, 2'd2, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b1};
    vecs[14] = '{1'b1, 2'd1, 2'd3, 8'd0, 3'b000, 3'b000, 3'b010, 1'b0};
    vecs[15] = '{1'b0, 2'd1, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b1};

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led",   {29'd0, led},  32'd0);
      check("rst_busy",  {29'd0, busy}, 32'd0);
      check("rst_done",  {29'd0, done}, 32'd0);
      check("rst_ready", {31'd0, cfg_ready}, 32'd0);
    end
    reset = 1'b0;
    step();
    check("ready_after_release", {31'd0, cfg_ready}, 32'd1);

    // Table: ON/OFF, handshake spacing, invalid channel, zero-count pulse
    for (int i = 0; i < 16; i++) begin
      cfg_valid = vecs[i].valid;
      cfg_ch    = vecs[i].ch;
      cfg_mode  = vecs[i].mode;
      cfg_half  = 8'd1;
      cfg_cnt   = vecs[i].cnt;
      step();
      check_led($sformatf("vec%0d_led", i), led, vecs[i].e_led);
      check($sformatf("vec%0d_busy", i),  {29'd0, busy}, {29'd0, vecs[i].e_busy});
      check($sformatf("vec%0d_done", i),  {29'd0, done}, {29'd0, vecs[i].e_done});
      check($sformatf("vec%0d_ready", i), {31'd0, cfg_ready}, {31'd0, vecs[i].e_ready});
    end
    cfg_valid = 1'b0;

`ifndef LED_PWM_EN
    // Continuous blink, half = 2 ticks = 8 clk
    do_cfg(2'd0, 2'd2, 8'd2, 8'd0);
    check("blink_led_start", {31'd0, led[0]},  32'd1);
    check("blink_busy",      {31'd0, busy[0]}, 32'd1);
    run_len(0, 1'b1, l0);
    run_len(0, 1'b0, l1);
    run_len(0, 1'b1, l2);
    run_len(0, 1'b0, l3);
    check("blink_first_phase_5to8", {31'd0, (l0 >= 5 && l0 <= 8)}, 32'd1);
    check("blink_lo1", l1, 32'd8);
    check("blink_hi2", l2, 32'd8);
    check("blink_lo2", l3, 32'd8);
    check("blink_busy_still", {31'd0, busy[0]}, 32'd1);
    do_cfg(2'd0, 2'd0, 8'd1, 8'd0);
    check("blink_off_led",  {31'd0, led[0]},  32'd0);
    check("blink_off_busy", {31'd0, busy[0]}, 32'd0);

    // Counted pulse: half = 1, three high phases
    do_cfg(2'd2, 2'd3, 8'd1, 8'd3);
    tl[0] = led[2];
    tb[0] = busy[2];
    td[0] = done[2];
    check("pulse_led_start",  {31'd0, tl[0]}, 32'd1);
    check("pulse_busy_start", {31'd0, tb[0]}, 32'd1);
    for (int i = 1; i < 64; i++) begin
      step();
      tl[i] = led[2];
      tb[i] = busy[2];
      td[i] = done[2];
    end
    rises = 0;
    done_n = 0;
    done_idx = -1;
    last_hi = -1;
    hl[0] = 0;
    hl[1] = 0;
    hl[2] = 0;
    for (int i = 0; i < 64; i++) begin
      if (tl[i] && (i == 0 || !tl[i-1])) rises++;
      if (tl[i] && rises >= 1 && rises <= 3) hl[rises-1]++;
      if (tl[i]) last_hi = i;
      if (td[i]) begin
        done_n++;
        done_idx = i;
      end
    end
    check("pulse_high_phases", rises, 32'd3);
    check("pulse_first_1to4", {31'd0, (hl[0] >= 1 && hl[0] <= 4)}, 32'd1);
    check("pulse_hi2_len", hl[1], 32'd4);
    check("pulse_hi3_len", hl[2], 32'd4);
    check("pulse_done_count", done_n, 32'd1);
    check("pulse_done_pos", done_idx, last_hi + 5);
    check("pulse_busy_fall", (done_idx > 0) ? {30'd0, tb[done_idx-1], tb[done_idx]} : 32'd0, 32'd2);
    check("pulse_busy_end", {31'd0, tb[63]}, 32'd0);

    // Override a running pulse with ON: no done, stays lit
    do_cfg(2'd2, 2'd3, 8'd2, 8'd5);
    for (int i = 0; i < 6; i++) step();
    check("ovr_busy_before", {31'd0, busy[2]}, 32'd1);
    do_cfg(2'd2, 2'd1, 8'd1, 8'd0);
    check("ovr_led",  {31'd0, led[2]},  32'd1);
    check("ovr_busy", {31'd0, busy[2]}, 32'd0);
    n_done = 0;
    n_dark = 0;
    for (int i = 0; i < 40; i++) begin
      if (done[2]) n_done++;
      if (!led[2]) n_dark++;
      step();
    end
    check("ovr_no_done", n_done, 32'd0);
    check("ovr_stays_lit", n_dark, 32'd0);
    do_cfg(2'd2, 2'd0, 8'd1, 8'd0);
`endif

    // Reset in the middle of a blink
    do_cfg(2'd0, 2'd2, 8'd1, 8'd0);
    check("rb_busy_before", {31'd0, busy[0]}, 32'd1);
    step();
    step();
    reset = 1'b1;
    step();
    check("rb_led",   {29'd0, led},  32'd0);
    check("rb_busy",  {29'd0, busy}, 32'd0);
    check("rb_done",  {29'd0, done}, 32'd0);
    check("rb_ready", {31'd0, cfg_ready}, 32'd0);
    reset = 1'b0;
    step();
    check("rb_ready_after", {31'd0, cfg_ready}, 32'd1);
    n_done = 0;
    n_dark = 0;
    for (int i = 0; i < 20; i++) begin
      if (done != 3'b000) n_done++;
      if (led != 3'b000 || busy != 3'b000) n_dark++;
      step();
    end
    check("rb_quiet_done", n_done, 32'd0);
    check("rb_quiet_led",  n_dark, 32'd0);

`ifdef LED_PWM_EN
    // Brightness: duty 64 lights 64 of every 256 clocks, duty 0 stays dark
    cfg_duty = 8'd64;
    do_cfg(2'd1, 2'd1, 8'd1, 8'd0);
    cfg_duty = 8'd0;
    do_cfg(2'd0, 2'd1, 8'd1, 8'd0);
    l0 = 0;
    l1 = 0;
    for (int i = 0; i < 256; i++) begin
      if (led[1]) l0++;
      if (led[0]) l1++;
      step();
    end
    check("pwm_duty64", l0, 32'd64);
    check("pwm_duty0",  l1, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
